// File: rtl/led_matrix_scanner_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_matrix_scanner_if : frame handoff from game logic to the LED scanner    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface led_matrix_scanner_if #(
    parameter int N = 15
);
    logic [N*N-1:0] cells_in;
    logic           cells_valid;
    logic           cells_ready;

    modport master (
        output cells_in,
        output cells_valid,
        input  cells_ready
    );

    modport slave (
        input  cells_in,
        input  cells_valid,
        output cells_ready
    );
endinterface
`default_nettype wire

// File: rtl/led_matrix_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_matrix_scanner : double-buffered row-multiplexed N x N LED driver       |
// | Optional macro LED_SCANNER_BLANKING_EN adds one blank cycle between rows.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module led_matrix_scanner #(
    parameter int N               = 15,
    parameter int DISPLAY_DIVIDER = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    led_matrix_scanner_if.slave       cells_if,
    output logic [N-1:0]              rows,
    output logic [N-1:0]              cols,
    output logic                      frame_start,
    output logic [$clog2(N)-1:0]      row_idx
);

    localparam int             RW        = $clog2(N);
    localparam int             DW        = (DISPLAY_DIVIDER > 0) ? DISPLAY_DIVIDER : 1;
    localparam logic [DW-1:0]  DWELL_MAX = DW'((1 << DISPLAY_DIVIDER) - 1);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(N - 1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
`ifdef LED_SCANNER_BLANKING_EN
        ST_BLANK = 2'd2,
`endif
        ST_SCAN  = 2'd1
    } state_t;

    state_t           state_q, state_d;
    logic [N*N-1:0]   display_q, display_d;
    logic [N*N-1:0]   staging_q, staging_d;
    logic             pending_q, pending_d;
    logic [RW-1:0]    row_q, row_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [N-1:0]     rows_q, rows_d;
    logic [N-1:0]     cols_q, cols_d;
    logic             frame_start_q, frame_start_d;
    logic [RW-1:0]    row_idx_q;
    logic             w_accept;
    logic             w_swap;

    assign w_accept             = cells_if.cells_valid && !pending_q;
    assign cells_if.cells_ready = !pending_q;

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        dwell_d       = dwell_q;
        display_d     = display_q;
        staging_d     = staging_q;
        pending_d     = pending_q;
        frame_start_d = 1'b0;
        w_swap        = 1'b0;
        rows_d        = '0;
        cols_d        = '1;

        case (state_q)
            ST_START: begin
                state_d       = ST_SCAN;
                row_d         = ROW_LAST;
                dwell_d       = '0;
                w_swap        = pending_q;
                frame_start_d = 1'b1;
            end
            ST_SCAN: begin
                if (dwell_q == DWELL_MAX) begin
                    dwell_d = '0;
                    if (row_q == '0) begin
                        row_d  = ROW_LAST;
                        w_swap = pending_q;
`ifndef LED_SCANNER_BLANKING_EN
                        frame_start_d = 1'b1;
`endif
                    end else begin
                        row_d = row_q - 1'b1;
                    end
`ifdef LED_SCANNER_BLANKING_EN
                    state_d = ST_BLANK;
`endif
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
`ifdef LED_SCANNER_BLANKING_EN
            ST_BLANK: begin
                state_d       = ST_SCAN;
                frame_start_d = (row_q == ROW_LAST);
            end
`endif
            default: begin
                state_d = ST_START;
            end
        endcase

        // Accept and swap are mutually exclusive: swap needs pending_q, accept needs !pending_q.
        if (w_accept) begin
            staging_d = cells_if.cells_in;
            pending_d = 1'b1;
        end
        if (w_swap) begin
            display_d = staging_q;
            pending_d = 1'b0;
        end

        if (state_d == ST_SCAN) begin
            rows_d = N'(1) << row_d;
            cols_d = ~display_d[int'(row_d)*N +: N];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_START;
            display_q     <= '0;
            staging_q     <= '0;
            pending_q     <= 1'b0;
            row_q         <= ROW_LAST;
            dwell_q       <= '0;
            rows_q        <= '0;
            cols_q        <= '1;
            frame_start_q <= 1'b0;
            row_idx_q     <= ROW_LAST;
        end else begin
            state_q       <= state_d;
            display_q     <= display_d;
            staging_q     <= staging_d;
            pending_q     <= pending_d;
            row_q         <= row_d;
            dwell_q       <= dwell_d;
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            frame_start_q <= frame_start_d;
            row_idx_q     <= row_d;
        end
    end

    assign rows        = rows_q;
    assign cols        = cols_q;
    assign frame_start = frame_start_q;
    assign row_idx     = row_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_led_matrix_scanner : directed self-checking bench, N=3, divider 1        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_led_matrix_scanner;

    localparam int N     = 3;
    localparam int DIV   = 1;
    localparam int DWELL = 2;
`ifdef LED_SCANNER_BLANKING_EN
    localparam int PERIOD   = N * (DWELL + 1);
    localparam int LAST_OFF = N * (DWELL + 1) - 2;
`else
    localparam int PERIOD   = N * DWELL;
    localparam int LAST_OFF = N * DWELL - 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] rows;
    logic [N-1:0] cols;
    logic         frame_start;
    logic [1:0]   row_idx;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] D1, A, B, C, D, E, tmp9;
    logic [2:0] ec;
    int         n;

    led_matrix_scanner_if #(.N(N)) bus ();

    led_matrix_scanner #(
        .N               (N),
        .DISPLAY_DIVIDER (DIV)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .cells_if    (bus),
        .rows        (rows),
        .cols        (cols),
        .frame_start (frame_start),
        .row_idx     (row_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs();
        int k = 0;
        while (frame_start !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        check("fs_reached", 32'(frame_start), 1);
    endtask

    // Starts on a frame_start cycle, ends on the next one.
    task automatic expect_frame(input logic [8:0] data);
        logic [2:0] exp_cols;
        check("frame_start", 32'(frame_start), 1);
        for (int r = N - 1; r >= 0; r--) begin
            exp_cols = ~data[r*N +: N];
            for (int d = 0; d < DWELL; d++) begin
                check("rows", 32'(rows), 32'(1 << r));
                check("cols", 32'(cols), 32'(exp_cols));
                tick();
            end
`ifdef LED_SCANNER_BLANKING_EN
            check("blank_rows", 32'(rows), 0);
            check("blank_cols", 32'(cols), 32'h7);
            tick();
`endif
        end
    endtask

    initial begin
        D1 = 9'b001_010_100;
        A  = 9'b111_000_101;
        B  = 9'b010_101_010;
        C  = 9'b110_011_001;
        D  = 9'b101_101_101;
        E  = 9'b011_110_000;

        // Reset state
        rst = 1'b1;
        bus.cells_valid = 1'b0;
        bus.cells_in    = '0;
        tick();
        tick();
        check("rst_rows", 32'(rows), 0);
        check("rst_cols", 32'(cols), 32'h7);
        check("rst_ready", 32'(bus.cells_ready), 1);
        check("rst_fs", 32'(frame_start), 0);
        check("rst_row_idx", 32'(row_idx), 2);
        rst = 1'b0;
        tick();
        check("start_rows", 32'(rows), 32'h4);
        check("start_fs", 32'(frame_start), 1);
        check("start_cols", 32'(cols), 32'h7);

        // Scan order
        bus.cells_in    = D1;
        bus.cells_valid = 1'b1;
        tick();
        bus.cells_valid = 1'b0;
        check("load_ready_low", 32'(bus.cells_ready), 0);
        wait_fs();
        expect_frame(D1);
        expect_frame(D1);

        // Backpressure
        bus.cells_in    = A;
        bus.cells_valid = 1'b1;
        tick();
        check("bp_a_ready_low", 32'(bus.cells_ready), 0);
        bus.cells_in = B;
        n = 0;
        while (bus.cells_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("bp_ready_back", 32'(bus.cells_ready), 1);
        check("bp_wait", 32'(n), 32'(LAST_OFF));
        tick();
        bus.cells_valid = 1'b0;
        check("bp_b_ready_low", 32'(bus.cells_ready), 0);
        check("bp_a_rows", 32'(rows), 32'h4);
        ec = ~A[8:6];
        check("bp_a_cols", 32'(cols), 32'(ec));
        tick();
        wait_fs();
        expect_frame(B);

        // No tearing: new frame presented during row 1
        n = 0;
        while (rows !== 3'b010 && n < 100) begin
            tick();
            n++;
        end
        check("tear_reach_row1", 32'(rows), 32'h2);
        bus.cells_in    = C;
        bus.cells_valid = 1'b1;
        tick();
        bus.cells_valid = 1'b0;
        n = 0;
        while (frame_start !== 1'b1 && n < 100) begin
            if (rows != '0) begin
                tmp9 = B >> (int'(row_idx) * N);
                ec   = ~tmp9[2:0];
                check("no_tear", 32'(cols), 32'(ec));
            end
            tick();
            n++;
        end
        wait_fs();
        expect_frame(C);

        // Reset mid-scan discards staged frame
        bus.cells_in    = D;
        bus.cells_valid = 1'b1;
        tick();
        bus.cells_valid = 1'b0;
        check("mid_pending", 32'(bus.cells_ready), 0);
        n = 0;
        while (rows !== 3'b010 && n < 100) begin
            tick();
            n++;
        end
        check("mid_reach_row1", 32'(rows), 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_rows", 32'(rows), 0);
        check("mid_rst_cols", 32'(cols), 32'h7);
        check("mid_rst_ready", 32'(bus.cells_ready), 1);
        tick();
        check("mid_restart_fs", 32'(frame_start), 1);
        expect_frame('0);
        expect_frame('0);

        // Frame accepted in row 0's final dwell cycle waits a whole frame
        for (int i = 0; i < LAST_OFF; i++) tick();
        check("last_dwell_row0", 32'(rows), 32'h1);
        bus.cells_in    = E;
        bus.cells_valid = 1'b1;
        tick();
        bus.cells_valid = 1'b0;
        check("late_ready_low", 32'(bus.cells_ready), 0);
        wait_fs();
        expect_frame('0);
        expect_frame(E);

        // Frame period
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < 100);
        check("frame_period", 32'(n), 32'(PERIOD));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
Downstream display stage of the Game of Life datapath. Takes the flat N×N cell vector produced by the game-step logic and time-multiplexes it onto the N×N LED array's row and column pins, one row at a time. Double-buffered with a valid/ready handshake, so a game update landing mid-frame never tears the displayed image.

Parameters:
N, 15, array dimension; cell vector is N*N bits, row r = cells[r*N +: N], bit c = column c.
DISPLAY_DIVIDER, 8, each row dwells for 2**DISPLAY_DIVIDER clock cycles; legal range 0..20.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
cells_in  input  N*N  next frame from the game logic.
cells_valid  input  1  cells_in holds a new frame.
cells_ready  output  1  staging buffer free; the transfer happens on a cycle where cells_valid && cells_ready.
rows  output  N  one-hot, active-high row drive.
cols  output  N  active-low column drive; cols[c]=0 lights cell (r,c).
frame_start  output  1  one-cycle pulse on the first cycle row N-1 is driven.
row_idx  output  $clog2(N)  row currently driven (debug/visibility).

Behaviour:
- All outputs are registered. Internal state: display_q (N*N), staging_q (N*N), pending_q, row_q, dwell_q (DISPLAY_DIVIDER bits), state_q.
- Reset (rst=1 at a rising edge):
  - rows=0, cols=all ones, frame_start=0, row_idx=N-1, cells_ready=1.
  - display_q=0, staging_q=0, pending_q=0, dwell_q=0, state=START.
  - Reset mid-frame aborts the scan immediately; a staged frame is discarded.
- Handshake:
  - cells_ready = !pending_q, combinational from the register.
  - On valid&&ready: staging_q<=cells_in, pending_q<=1.
  - While pending_q=1, cells_valid is ignored; the producer holds it.
  - On a swap: display_q<=staging_q, pending_q<=0.
  - Accept and swap in the same cycle cannot happen, because ready=0 whenever a swap is possible.
- States:
  - START: one cycle after reset; outputs blank.
    - Next: swap if pending, set row_q=N-1, go to SCAN.
    - frame_start=1 on the first SCAN cycle.
  - SCAN:
    - rows = 1<<row_q; cols = ~display_q[row_q*N +: N].
    - dwell_q increments each cycle. When dwell_q == 2**DISPLAY_DIVIDER-1, it clears and the row advances.
    - Row advance:
      - row_q>0: row_q<=row_q-1.
      - row_q==0: row_q<=N-1, swap if pending, frame_start pulses on the next cycle.
    - With DISPLAY_DIVIDER=0, every row lasts exactly 1 cycle.
  - BLANK: exists only with the macro below.
- Frame period without blanking: N * 2**DISPLAY_DIVIDER cycles.
- Row order is N-1 down to 0, so the top printed row is scanned first.
- The new image first appears on the first row-N-1 cycle after the swap. It is never visible partway through a frame.
- A frame accepted during row 0's final dwell cycle is not swapped until the next wrap. The accept-register write lands after the wrap decision.

Optional Feature:
LED_SCANNER_BLANKING_EN
- Defined: anti-ghosting blank cycle between rows.
  - After each row's dwell, state goes to BLANK for exactly 1 cycle: rows=0, cols=all ones.
  - The row decrement and any wrap swap happen on entry to BLANK.
  - The following SCAN cycle drives the new row. frame_start pulses on the first SCAN cycle of row N-1.
  - Frame period: N*(2**DISPLAY_DIVIDER+1) cycles.
- Undefined: BLANK state not built; rows change back-to-back as described above.

Test Plan:
- Reset: N=3, DISPLAY_DIVIDER=1; hold rst 2 cycles, then check:
  - rows=3'b000, cols=3'b111, cells_ready=1.
  - The cycle after START: rows=3'b100, frame_start=1.
- Scan order: load cells_in=9'b001_010_100 via handshake; after the next wrap, the sequence is:
  - rows=100 with cols=110, 2 cycles.
  - rows=010 with cols=101, 2 cycles.
  - rows=001 with cols=011, 2 cycles.
  - Then repeat.
- Backpressure: assert cells_valid with A, then B on the next cycle.
  - A is accepted; cells_ready=0 until the wrap swap.
  - B is accepted the cycle after the swap and displayed one frame later.
- No tearing: present a new frame during row 1; rows 1 and 0 of the current frame still show the old data, and the new data appears at the next rows=100.
- Reset mid-scan: assert rst while rows=010 with pending=1; the next cycle has rows=0, cols=all ones, cells_ready=1, and the staged frame is never shown.
- Blanking (macro defined, N=3, DIV=1):
  - frame_start pulses every 9 cycles.
  - Between each row a single cycle with rows=000, cols=111.
  - Without the macro, the pulse period is 6 cycles.
